// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS HI/LO multiply/divide engine.
// One start cycle, WIDTH iteration cycles, one sign-fix cycle, then a done pulse.
// MULT/MULTU use shift-add. DIV/DIVU use restoring division on magnitudes.
// Optional macro MDU_ABORT_EN adds an 'abort' input that flushes a running operation.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MDU_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t               state_r, state_n;
  logic [CNT_W-1:0]     cnt_r;
  logic                 is_div_r;
  logic                 neg_q_r;     // negate product / quotient
  logic                 neg_rem_r;   // remainder takes dividend sign
  logic                 dz_r;        // divide by zero
  logic [WIDTH-1:0]     b_r;         // multiplicand / divisor magnitude
  logic [WIDTH-1:0]     a_raw_r;     // original dividend for div-by-zero HI
  logic [2*WIDTH-1:0]   acc_r, acc_n;
  logic [WIDTH-1:0]     res_hi_s, res_lo_s;
  logic                 abort_s;

  // Magnitude of a two's-complement value when signed handling is requested.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      mag = -v;
    end else begin
      mag = v;
    end
  endfunction

`ifdef MDU_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN for WIDTH cycles, FIX for one cycle.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (abort_s) begin
          state_n = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_n = FIX;
        end else begin
          state_n = RUN;
        end
      end
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide on the accumulator.
  always_comb begin
    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] shl_s;
    logic [WIDTH:0] diff_s;
    sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, (acc_r[0] ? b_r : {WIDTH{1'b0}})};
    shl_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    diff_s = shl_s - {1'b0, b_r};
    if (!is_div_r) begin
      acc_n = {sum_s, acc_r[WIDTH-1:1]};
    end else if (!diff_s[WIDTH]) begin
      acc_n = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      acc_n = {shl_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction and div-by-zero override applied in the FIX cycle.
  always_comb begin
    logic [2*WIDTH-1:0] prod_s;
    prod_s = neg_q_r ? -acc_r : acc_r;
    if (!is_div_r) begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end else if (dz_r) begin
      res_hi_s = a_raw_r;
      res_lo_s = {WIDTH{1'b1}};
    end else begin
      res_hi_s = neg_rem_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
      res_lo_s = neg_q_r   ? -acc_r[WIDTH-1:0]       : acc_r[WIDTH-1:0];
    end
  end

  // Datapath: operand latch, iteration, HI/LO writes and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      HI        <= {WIDTH{1'b0}};
      LO        <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      is_div_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      dz_r      <= 1'b0;
      b_r       <= {WIDTH{1'b0}};
      a_raw_r   <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
    end else begin
      busy <= (state_n != IDLE);
      done <= (state_r == FIX) && !abort_s;
      case (state_r)
        IDLE: begin
          cnt_r <= {CNT_W{1'b0}};
          if (start) begin
            is_div_r  <= op[1];
            neg_q_r   <= !op[0] && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_rem_r <= !op[0] && op[1] && A[WIDTH-1];
            dz_r      <= op[1] && (B == {WIDTH{1'b0}});
            b_r       <= mag(B, !op[0]);
            a_raw_r   <= A;
            acc_r     <= {{WIDTH{1'b0}}, mag(A, !op[0])};
          end else begin
            if (hi_we) HI <= wdata;
            if (lo_we) LO <= wdata;
          end
        end
        RUN: begin
          acc_r <= acc_n;
          cnt_r <= cnt_r + CNT_ONE;
        end
        FIX: begin
          if (!abort_s) begin
            HI <= res_hi_s;
            LO <= res_lo_s;
          end
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule
